// File: rtl/fetch_issue_pkg.sv
// Shared types for the fetch consumer: in-flight tracking entries, queue entries
// and the fetch address reset value.
package fetch_issue_pkg;

    localparam logic [31:0] PC_RESET = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } inflight_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } qentry_t;

    localparam int QW = $bits(qentry_t);

endpackage

// File: rtl/ins_fifo.sv
// Synchronous FIFO with flush and occupancy output; holds arrived instruction
// words until decode accepts them.
module ins_fifo
    import fetch_issue_pkg::*;
#(
    parameter  int WIDTH = QW,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~i_flush;
    assign w_do_pop  = i_pop & (r_count != '0) & ~i_flush;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; occupancy alone decides
    // validity, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_issue.sv
// Consumer end of the fetch interface: launch control, in-flight tracking and
// credit-based hold, producing a valid/ready instruction stream for decode.
module fetch_issue
    import fetch_issue_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ins,
    output logic        hold,
    output logic        jmp_en,
    output logic [31:0] jmp_addr,
    output logic        clr,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        restart,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_launch_pc;
    inflight_t     r_pipe [LAT];

    logic          w_flush;
    logic          w_launch;
    logic          w_push;
    logic [31:0]   w_next_pc;
    logic [31:0]   w_inflight;
    logic [31:0]   w_credit;
    logic [CW-1:0] w_count;
    logic          w_fifo_valid;
    logic [QW-1:0] w_fifo_rdata;
    qentry_t       w_push_entry;
    qentry_t       w_head;

    // NOTE: every signal written here gets a default before any conditional
    // assignment, so no path leaves a value held and no latch is inferred.
    always_comb begin
        clr        = restart;
        jmp_en     = redir_valid & ~restart;
        jmp_addr   = '0;
        w_inflight = '0;
        w_next_pc  = r_launch_pc;

        if (jmp_en) jmp_addr = redir_target - r_launch_pc;

        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + 32'(r_pipe[i].valid);
        end
        // Pops in this cycle are not credited, so overflow cannot occur.
        w_credit = 32'(w_count) + w_inflight;
        hold     = (w_credit >= 32'(DEPTH));

        w_flush  = clr | jmp_en;
        w_launch = ~clr & (jmp_en | ~hold);

        if (clr)         w_next_pc = PC_RESET;
        else if (jmp_en) w_next_pc = redir_target;
        else if (!hold)  w_next_pc = r_launch_pc + 32'd1;
    end

    // The word on ins belongs to the entry at the output end of the pipe.
    assign w_push       = r_pipe[LAT-1].valid & ~w_flush;
    assign w_push_entry = '{ins: ins, pc: r_pipe[LAT-1].pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_launch_pc <= PC_RESET;
            for (int i = 0; i < LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_launch_pc <= w_next_pc;
            r_pipe[0]   <= '{valid: w_launch, pc: w_next_pc};
            for (int i = 1; i < LAT; i++) begin
                r_pipe[i] <= '{valid: r_pipe[i-1].valid & ~w_flush, pc: r_pipe[i-1].pc};
            end
        end
    end

    ins_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (out_ready),
        .o_data  (w_fifo_rdata),
        .o_valid (w_fifo_valid),
        .o_count (w_count)
    );

    assign w_head    = qentry_t'(w_fifo_rdata);
    assign out_valid = w_fifo_valid;
    assign out_ins   = w_head.ins;
    assign out_pc    = w_head.pc;

endmodule
